// File: rtl/mips_pkg.sv
// Shared execute-stage definitions: ALU control codes, multiply/divide FSM states, iteration count.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package mips_pkg;

    localparam logic [3:0] ALU_AND  = 4'b0000;
    localparam logic [3:0] ALU_OR   = 4'b0001;
    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_MULT = 4'b0011;
    localparam logic [3:0] ALU_DIV  = 4'b0100;
    localparam logic [3:0] ALU_SUB  = 4'b0110;
    localparam logic [3:0] ALU_SLT  = 4'b0111;

    // One radix-2 step per cycle over a 32-bit operand.
    localparam int MULDIV_ITERS = 32;

    typedef enum logic [2:0] {
        MD_IDLE = 3'd0,
        MD_MUL  = 3'd1,
        MD_DIV  = 3'd2,
        MD_FIX  = 3'd3,
        MD_DONE = 3'd4
    } muldiv_state_t;

    // True for the control codes that the multi-cycle unit acts on.
    function automatic logic is_muldiv_code(input logic [3:0] code);
        return (code == ALU_MULT) || (code == ALU_DIV);
    endfunction

endpackage

// File: rtl/muldiv_datapath.sv
// Radix-2 shift-add multiply / restoring shift-subtract divide on unsigned magnitudes.
// Latency: one iteration per cycle with step high; load takes one cycle.
// Backpressure: none; the controlling FSM decides when load/step fire.
module muldiv_datapath #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             step,
    input  logic             is_div,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic [WIDTH-1:0] upper,
    output logic [WIDTH-1:0] lower
);

    // acc holds {partial product, multiplier} for mult, {remainder, dividend/quotient} for div.
    logic [2*WIDTH-1:0] acc_q;
    logic [WIDTH-1:0]   opnd_q;
    logic               div_mode_q;

    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next;
    logic [WIDTH:0]     rem_shift;
    logic [WIDTH:0]     rem_diff;
    logic               rem_ge;
    logic [2*WIDTH-1:0] div_next;

    // Next accumulator value for one multiply step and one divide step.
    always_comb begin
        mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
        mul_next  = {mul_sum, acc_q[WIDTH-1:1]};
        rem_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
        rem_diff  = rem_shift - {1'b0, opnd_q};
        // Remainder stays below the divisor, so a clear top bit means the trial subtract fit.
        rem_ge    = ~rem_diff[WIDTH];
        div_next  = rem_ge ? {rem_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1}
                           : {rem_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
    end

    // Load operands on accept, then advance one iteration per step.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q      <= '0;
            opnd_q     <= '0;
            div_mode_q <= 1'b0;
        end else if (load) begin
            div_mode_q <= is_div;
            if (is_div) begin
                acc_q  <= {{WIDTH{1'b0}}, op_a};
                opnd_q <= op_b;
            end else begin
                acc_q  <= {{WIDTH{1'b0}}, op_b};
                opnd_q <= op_a;
            end
        end else if (step) begin
            acc_q <= div_mode_q ? div_next : mul_next;
        end
    end

    assign upper = acc_q[2*WIDTH-1:WIDTH];
    assign lower = acc_q[WIDTH-1:0];

endmodule

// File: rtl/mul_div_unit.sv
// Iterative 32-bit mult/div into HI/LO; signed when MULDIV_SIGNED_EN is defined, else unsigned.
// Latency: 34 cycles from accepting edge to done (1 cycle for divide by zero).
// Backpressure: busy stalls the pipeline; start while busy is dropped, no queueing.
module mul_div_unit
    import mips_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [3:0]       control,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             div_zero
);

    localparam logic [5:0] ITERS = 6'(MULDIV_ITERS);

    muldiv_state_t    state_q, state_d;
    logic [5:0]       cnt_q;
    logic             accept;
    logic             req_div;
    logic             b_zero;
    logic             dp_load;
    logic             dp_step;
    logic [WIDTH-1:0] a_mag, b_mag;
    logic [WIDTH-1:0] raw_hi, raw_lo;
    logic [WIDTH-1:0] fix_hi, fix_lo;

    assign accept  = (state_q == MD_IDLE) && start && is_muldiv_code(control);
    assign req_div = (control == ALU_DIV);
    assign b_zero  = (b == '0);

`ifdef MULDIV_SIGNED_EN
    logic             a_neg, b_neg;
    logic             mode_div_q;
    logic             neg_prod_q, neg_quo_q, neg_rem_q;
    logic [2*WIDTH-1:0] prod_neg;

    assign a_neg = a[WIDTH-1];
    assign b_neg = b[WIDTH-1];
    // 0x8000_0000 negates to itself, which is its correct unsigned magnitude.
    assign a_mag = a_neg ? -a : a;
    assign b_mag = b_neg ? -b : b;

    // Capture result signs alongside the operands.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_div_q <= 1'b0;
            neg_prod_q <= 1'b0;
            neg_quo_q  <= 1'b0;
            neg_rem_q  <= 1'b0;
        end else if (accept) begin
            mode_div_q <= req_div;
            neg_prod_q <= a_neg ^ b_neg;
            neg_quo_q  <= a_neg ^ b_neg;
            neg_rem_q  <= a_neg;
        end
    end

    // Sign correction: product negated as a whole, quotient toward zero, remainder follows dividend.
    always_comb begin
        prod_neg = -{raw_hi, raw_lo};
        fix_hi   = raw_hi;
        fix_lo   = raw_lo;
        if (mode_div_q) begin
            fix_hi = neg_rem_q ? -raw_hi : raw_hi;
            fix_lo = neg_quo_q ? -raw_lo : raw_lo;
        end else if (neg_prod_q) begin
            {fix_hi, fix_lo} = prod_neg;
        end
    end
`else
    assign a_mag  = a;
    assign b_mag  = b;
    assign fix_hi = raw_hi;
    assign fix_lo = raw_lo;
`endif

    muldiv_datapath #(
        .WIDTH (WIDTH)
    ) u_datapath (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (dp_load),
        .step   (dp_step),
        .is_div (req_div),
        .op_a   (a_mag),
        .op_b   (b_mag),
        .upper  (raw_hi),
        .lower  (raw_lo)
    );

    // Next-state and datapath control.
    always_comb begin
        state_d = state_q;
        dp_load = 1'b0;
        dp_step = 1'b0;
        case (state_q)
            MD_IDLE: begin
                if (accept) begin
                    if (req_div && b_zero) begin
                        state_d = MD_DONE;
                    end else begin
                        dp_load = 1'b1;
                        state_d = req_div ? MD_DIV : MD_MUL;
                    end
                end
            end
            MD_MUL, MD_DIV: begin
                dp_step = 1'b1;
                if (cnt_q == 6'd1) begin
                    state_d = MD_FIX;
                end
            end
            MD_FIX:  state_d = MD_DONE;
            MD_DONE: state_d = MD_IDLE;
            default: state_d = MD_IDLE;
        endcase
    end

    // State register and iteration counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= MD_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                cnt_q <= ITERS;
            end else if (dp_step) begin
                cnt_q <= cnt_q - 6'd1;
            end
        end
    end

    // Registered status outputs; done is a pulse one cycle after the DONE state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy     <= 1'b0;
            done     <= 1'b0;
            div_zero <= 1'b0;
        end else begin
            done <= (state_q == MD_DONE);
            if (accept) begin
                busy     <= 1'b1;
                div_zero <= req_div && b_zero;
            end else if (state_q == MD_DONE) begin
                busy <= 1'b0;
            end
        end
    end

    // HI/LO written only by FIX or by a divide-by-zero accept; held otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi <= '0;
            lo <= '0;
        end else if (accept && req_div && b_zero) begin
            hi <= a;
            lo <= '1;
        end else if (state_q == MD_FIX) begin
            hi <= fix_hi;
            lo <= fix_lo;
        end
    end

endmodule
